// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the CPU datapath (master) and the multiply/divide unit (slave).
// No pipelining here; the master stalls on busy before reissuing.
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] rs_dat;
    logic [DATA_W-1:0] rt_dat;
    logic [DATA_W-1:0] hi_dat;
    logic [DATA_W-1:0] lo_dat;
    logic              busy;

    modport master (
        output start, op, rs_dat, rt_dat,
        input  hi_dat, lo_dat, busy
    );

    modport slave (
        input  start, op, rs_dat, rt_dat,
        output hi_dat, lo_dat, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with HI/LO; MTHI/MTLO take effect at the issuing edge, mul/div hold busy 33 cycles.
// Backpressure: busy is high while an operation is in flight and every start during that window is dropped.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    // r_rem is the running upper product half (mul) or partial remainder (div);
    // r_quo is the multiplier being shifted out (mul) or dividend/quotient (div).
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_b;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_signed_op;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_shift;
    logic                w_div_ge;
    logic [DATA_W-1:0]   w_div_sub;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    assign w_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_a_neg     = w_signed_op & bus.rs_dat[DATA_W-1];
    assign w_b_neg     = w_signed_op & bus.rt_dat[DATA_W-1];
    assign w_a_mag     = w_a_neg ? (~bus.rs_dat + 1'b1) : bus.rs_dat;
    assign w_b_mag     = w_b_neg ? (~bus.rt_dat + 1'b1) : bus.rt_dat;

    // Shift-add: conditionally add multiplicand to the upper half, then shift the pair right.
    assign w_mul_sum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});

    // Restoring divide: the partial remainder stays below the divisor, so the difference fits DATA_W bits.
    assign w_div_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[DATA_W-1:0] - r_b;

    assign w_prod      = {r_rem, r_quo};
    assign w_prod_fix  = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix   = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix   = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                r_rem    <= '0;
                                r_quo    <= w_b_mag;
                                r_b      <= w_a_mag;
                                r_is_div <= 1'b0;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= 1'b0;
                                r_cnt    <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_rem    <= '0;
                                r_quo    <= w_a_mag;
                                r_b      <= w_b_mag;
                                r_is_div <= 1'b1;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_cnt    <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_MTHI: r_hi <= bus.rs_dat;
                            OP_MTLO: r_lo <= bus.rs_dat;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_rem <= w_div_ge ? w_div_sub : w_div_shift[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], w_div_ge};
                    end else begin
                        r_rem <= w_mul_sum[DATA_W:1];
                        r_quo <= {w_mul_sum[0], r_quo[DATA_W-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(ITER - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor leaves the architectural registers untouched.
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                        r_lo <= w_prod_fix[DATA_W-1:0];
                    end else if (r_b != '0) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi_dat = r_hi;
    assign bus.lo_dat = r_lo;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vector table, multi-cycle corner sequences and a random run against an arithmetic model.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit_if #(.DATA_W(32)) bus ();

    muldiv_unit #(.DATA_W(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference semantics straight from the architectural definition, using 64-bit host arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint q;
        longint r;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd2: begin
                p = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_hi = r[31:0]; m_lo = q[31:0];
            end
            3'd4: if (b != 0) begin
                m_hi = a % b; m_lo = a / b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic issue_short(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_dat = a; bus.rt_dat = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd0;
    endtask

    task automatic start_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_dat = a; bus.rt_dat = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd0;
        bus.rs_dat = $urandom; bus.rt_dat = $urandom;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_err = 0;
        bus.start = 1'b0; bus.op = 3'd0; bus.rs_dat = '0; bus.rt_dat = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_hi", bus.hi_dat, 32'h0);
        chk("reset_lo", bus.lo_dat, 32'h0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);

        // MTHI then MTLO in successive cycles
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.rs_dat = 32'h12345678;
        @(posedge clk); #1;
        chk("mthi_hi", bus.hi_dat, 32'h12345678);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        bus.op = 3'd6; bus.rs_dat = 32'h9ABCDEF0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd0;
        chk("mtlo_lo", bus.lo_dat, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", bus.hi_dat, 32'h12345678);
        chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);

        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
        vecs.push_back('{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"});
        vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"});
        vecs.push_back('{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7"});
        vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"});
        vecs.push_back('{3'd3, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"});
        vecs.push_back('{3'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, "div_m100_m7"});
        vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq"});
        vecs.push_back('{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, "mult_maxmin"});
        vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu_by1"});

        for (int i = 0; i < vecs.size(); i++) begin
            start_long(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(cyc);
            chk({vecs[i].name, "_cycles"}, cyc, 32'd33);
            chk({vecs[i].name, "_hi"}, bus.hi_dat, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, bus.lo_dat, vecs[i].lo);
        end

        // Divide by zero with a preset HI/LO, plus an MTLO attempt while busy
        issue_short(3'd5, 32'hAAAA0000);
        issue_short(3'd6, 32'h0000BBBB);
        start_long(3'd4, 32'd5, 32'd0);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            if (cyc == 10) begin
                bus.start = 1'b1; bus.op = 3'd6; bus.rs_dat = 32'hDEADBEEF;
            end else begin
                bus.start = 1'b0; bus.op = 3'd0;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc < 33) chk("div0_hold_lo", bus.lo_dat, 32'h0000BBBB);
        end
        bus.start = 1'b0; bus.op = 3'd0;
        chk("div0_cycles", cyc, 32'd33);
        chk("div0_hi", bus.hi_dat, 32'hAAAA0000);
        chk("div0_lo", bus.lo_dat, 32'h0000BBBB);

        // Reset in the middle of a multiply
        start_long(3'd1, 32'h01234567, 32'h89ABCDEF);
        repeat (14) begin @(posedge clk); #1; end
        chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_hi", bus.hi_dat, 32'h0);
        chk("rst_mid_lo", bus.lo_dat, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_long(3'd2, 32'd3, 32'd4);
        wait_idle(cyc);
        chk("post_rst_cycles", cyc, 32'd33);
        chk("post_rst_hi", bus.hi_dat, 32'h0);
        chk("post_rst_lo", bus.lo_dat, 32'd12);

        // Random operations against the model
        m_hi = 32'h0;
        m_lo = 32'd12;
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            model(rop, ra, rb);
            if (rop >= 3'd1 && rop <= 3'd4) begin
                start_long(rop, ra, rb);
                wait_idle(cyc);
                chk("rand_cycles", cyc, 32'd33);
            end else begin
                issue_short(rop, ra);
                chk("rand_busy_short", {31'd0, bus.busy}, 32'd0);
            end
            chk("rand_hi", bus.hi_dat, m_hi);
            chk("rand_lo", bus.lo_dat, m_lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS single-cycle CPU.
- Sits directly downstream of the register file. Consumes RsData/RtData as operands for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Supplies HI/LO to the writeback mux for MFHI/MFLO.
- Raises Busy so the control unit can stall the PC while an operation is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- ITER, 32, iteration cycles per multiply/divide (equals DATA_W).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  operation request, sampled at posedge when Busy=0.
- Op  in  3  operation code:
  - 000 none
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MTHI
  - 110 MTLO
  - 111 none
- RsData  in  32  operand A (dividend/multiplicand; source for MTHI/MTLO).
- RtData  in  32  operand B (divisor/multiplier).
- HiData  out  32  current HI register.
- LoData  out  32  current LO register.
- Busy  out  1  high while a multiply/divide is in progress.

Behaviour:
- Reset (rst_n=0, async): HI=0, LO=0, Busy=0, state=IDLE, iteration counter=0. Reset mid-operation aborts the operation; HI/LO read 0 after reset.
- States: IDLE, RUN, FIX.
- IDLE:
  - Start=1 with Op in {001..100} at edge k: latch operand magnitudes and sign flags, clear counter, go to RUN.
  - Start=1 with Op=101: HI<=RsData at edge k; LO unchanged; stay IDLE.
  - Start=1 with Op=110: LO<=RsData at edge k; HI unchanged; stay IDLE.
  - Op 000/111, or Start=0: no change.
- RUN:
  - One radix-2 step per edge: shift-add for multiply, restoring subtract for divide.
  - Counter increments each edge. After the 32nd step (edge k+32), go to FIX.
- FIX (edge k+33):
  - Apply sign correction and write HI/LO together; go to IDLE.
  - HI/LO hold their old values throughout RUN; no partial results are visible.
- Busy = (state != IDLE). It is high for exactly 33 cycles: after edge k until edge k+33. New HI/LO are visible the cycle Busy falls.
- Start while Busy=1 is ignored for every Op, including MTHI/MTLO. The control unit must stall on Busy.
- MULT/MULTU: {HI,LO} = full 64-bit product. MULT treats operands as two's complement; MULTU as unsigned.
- DIVU: LO = unsigned quotient, HI = unsigned remainder.
- DIV:
  - Operates on magnitudes, then corrects signs.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend; truncation is toward zero.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000 (wraps, no trap).
- Divide by zero (RtData=0, DIV or DIVU): the full 33-cycle sequence runs; HI and LO are left unchanged at FIX.
- Operands are captured at edge k. Changes on RsData/RtData during RUN have no effect.
- HiData/LoData are driven directly from the registers with no combinational path from the inputs.

Test Plan:
- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 in successive cycles -> HiData=0x12345678, LoData=0x9ABCDEF0 one edge later each; Busy stays 0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU 5/0 with HI=0xAAAA0000, LO=0x0000BBBB preset -> Busy 33 cycles; HI/LO unchanged. MTLO issued at cycle 10 of Busy is ignored.
- rst_n pulled low at cycle 15 of a MULT -> Busy=0, HI=LO=0 immediately. After release, a new MULTU 3x4 gives LO=12, HI=0.
